// File: rtl/matrix_vector_sequencer_if.sv
// matrix_vector_sequencer_if: matrix-row write port, vertex input stream and result output stream.
// Vectors are packed {x, y, z, w} with x in the top 32 bits, Q16.16 signed.
interface matrix_vector_sequencer_if;
    logic         matrix_we;
    logic [1:0]   matrix_row_index;
    logic [127:0] matrix_row;
    logic         matrix_ready;
    logic         vertex_valid;
    logic         vertex_ready;
    logic [127:0] vertex;
    logic         result_valid;
    logic         result_ready;
    logic [127:0] result;
    modport master (
        output matrix_we, matrix_row_index, matrix_row, vertex_valid, vertex, result_ready,
        input  matrix_ready, vertex_ready, result_valid, result
    );
    modport slave (
        input  matrix_we, matrix_row_index, matrix_row, vertex_valid, vertex, result_ready,
        output matrix_ready, vertex_ready, result_valid, result
    );
endinterface

// File: rtl/matrix_vector_sequencer.sv
// matrix_vector_sequencer: 4x4 Q16.16 matrix times vertex stream, one shared dot product per row per cycle.
// Row k of the matrix produces result component k (0 -> x ... 3 -> w); sums wrap modulo 2^32.
module matrix_vector_sequencer (
    input logic clk,
    input logic rst,
    matrix_vector_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    localparam logic [3:0][3:0][31:0] IDENTITY = {
        {96'h0, 32'h0001_0000},
        {64'h0, 32'h0001_0000, 32'h0},
        {32'h0, 32'h0001_0000, 64'h0},
        {32'h0001_0000, 96'h0}
    };
    state_t state, state_nx;
    logic [1:0] k;
    logic [3:0][3:0][31:0] mat;
    logic [3:0][31:0] vec, res;
    logic [31:0] dot;
    logic accept;
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        return p[47:16];
    endfunction
    always_comb begin
        bus.vertex_ready = (state == IDLE) || (state == DONE && bus.result_ready);
        accept = bus.vertex_ready && bus.vertex_valid;
        state_nx = state;
        if (state == IDLE)
            state_nx = accept ? COMPUTE : IDLE;
        else if (state == COMPUTE)
            state_nx = (k == 2'd3) ? DONE : COMPUTE;
        else if (state == DONE)
            state_nx = bus.result_ready ? (bus.vertex_valid ? COMPUTE : IDLE) : DONE;
        dot = fmul(mat[k][3], vec[3]) + fmul(mat[k][2], vec[2])
            + fmul(mat[k][1], vec[1]) + fmul(mat[k][0], vec[0]);
    end
    assign bus.matrix_ready = state == IDLE;
    assign bus.result_valid = state == DONE;
    assign bus.result = res;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= 2'd0;
            res <= '0;
            vec <= '0;
            mat <= IDENTITY;
        end else begin
            state <= state_nx;
            if (bus.matrix_we && bus.matrix_ready)
                mat[bus.matrix_row_index] <= bus.matrix_row;
            if (accept) begin
                vec <= bus.vertex;
                k <= 2'd0;
            end else if (state == COMPUTE) begin
                k <= k + 2'd1;
            end
            // component x lives in the top word, so row k lands in word 3-k
            if (state == COMPUTE)
                res[2'd3 - k] <= dot;
        end
    end
endmodule
